// File: rtl/rom_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// rom_fetch_sequencer_if : ROM bus, decoder handshake and redirect signals
// Rev 1.0
// ============================================================================
interface rom_fetch_sequencer_if;
  logic        en;
  logic [7:0]  rom_address;
  logic [15:0] rom_value;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halted;
  logic        fault;

  modport master (
    input  en, rom_value, instr_ready, redirect, redirect_pc,
    output rom_address, instr, instr_pc, instr_valid, halted, fault
  );

  modport slave (
    output en, rom_value, instr_ready, redirect, redirect_pc,
    input  rom_address, instr, instr_pc, instr_valid, halted, fault
  );
endinterface
`default_nettype wire

// File: rtl/rom_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// rom_fetch_sequencer : PC / instruction-fetch controller for the program ROM
// Rev 1.0
// ============================================================================
module rom_fetch_sequencer #(
  parameter int          ROM_DEPTH   = 8,
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter logic [15:0] HALT_OPCODE = 16'h0000
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  rom_fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALT    = 2'd1,
    ST_FAULTED = 2'd2
  } state_t;

  localparam logic [8:0] c_depth   = 9'(ROM_DEPTH);
  localparam logic [7:0] c_last_pc = 8'(ROM_DEPTH - 1);

  state_t      r_state;
  logic [7:0]  r_pc;
  logic [15:0] r_instr;
  logic [7:0]  r_instr_pc;
  logic        r_valid;
  logic        r_halted;
  logic        r_fault;

  logic        w_load;
  logic        w_target_ok;
  logic [7:0]  w_next_pc;

  assign w_load = (r_state == ST_RUN) && bus.en && !bus.redirect &&
                  (!r_valid || bus.instr_ready);
  assign w_target_ok = ({1'b0, bus.redirect_pc} < c_depth);
  assign w_next_pc   = (r_pc == c_last_pc) ? 8'h00 : r_pc + 8'h01;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_instr    <= 16'h0000;
      r_instr_pc <= 8'h00;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
    end else if (bus.redirect && (r_state != ST_FAULTED)) begin
      // A redirect always flushes the pending word, even if it is being accepted.
      r_valid <= 1'b0;
      if (w_target_ok) begin
        r_pc     <= bus.redirect_pc;
        r_state  <= ST_RUN;
        r_halted <= 1'b0;
      end else begin
        r_state  <= ST_FAULTED;
        r_halted <= 1'b1;
        r_fault  <= 1'b1;
      end
    end else if (w_load) begin
      r_instr    <= bus.rom_value;
      r_instr_pc <= r_pc;
      r_valid    <= 1'b1;
      r_pc       <= w_next_pc;
      if (bus.rom_value == HALT_OPCODE) begin
        r_state  <= ST_HALT;
        r_halted <= 1'b1;
      end
    end else if (r_valid && bus.instr_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.rom_address = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;
  assign bus.halted      = r_halted;
  assign bus.fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_rom_fetch_sequencer : directed self-checking bench for rom_fetch_sequencer
// Rev 1.0
// ============================================================================
module tb_rom_fetch_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  rom_fetch_sequencer_if bus_a ();
  rom_fetch_sequencer_if bus_b ();

  rom_fetch_sequencer #(
    .ROM_DEPTH   (8),
    .RESET_PC    (8'h00),
    .HALT_OPCODE (16'h0000)
  ) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  rom_fetch_sequencer #(
    .ROM_DEPTH   (8),
    .RESET_PC    (8'h00),
    .HALT_OPCODE (16'hDEAD)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  function automatic logic [15:0] rom_rd(input logic [7:0] a);
    case (a)
      8'd0:    rom_rd = 16'h1003;
      8'd1:    rom_rd = 16'hFFFF;
      8'd2:    rom_rd = 16'hFFFF;
      8'd3:    rom_rd = 16'h4001;
      8'd4:    rom_rd = 16'h5200;
      8'd5:    rom_rd = 16'h1003;
      8'd6:    rom_rd = 16'h0000;
      8'd7:    rom_rd = 16'h0000;
      default: rom_rd = 16'hBAD0;
    endcase
  endfunction

  assign bus_a.rom_value = rom_rd(bus_a.rom_address);
  assign bus_b.rom_value = rom_rd(bus_b.rom_address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_instr [7];
  logic [15:0] exp_b     [3];
  logic [7:0]  exp_b_pc  [3];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_instr[0] = 16'h1003; exp_instr[1] = 16'hFFFF; exp_instr[2] = 16'hFFFF;
    exp_instr[3] = 16'h4001; exp_instr[4] = 16'h5200; exp_instr[5] = 16'h1003;
    exp_instr[6] = 16'h0000;
    exp_b[0] = 16'h0000; exp_b[1] = 16'h1003; exp_b[2] = 16'hFFFF;
    exp_b_pc[0] = 8'd7;  exp_b_pc[1] = 8'd0;  exp_b_pc[2] = 8'd1;

    rst_n = 1'b0;
    bus_a.en = 1'b1; bus_a.instr_ready = 1'b1; bus_a.redirect = 1'b0; bus_a.redirect_pc = 8'h00;
    bus_b.en = 1'b1; bus_b.instr_ready = 1'b1; bus_b.redirect = 1'b0; bus_b.redirect_pc = 8'h00;
    tick();
    tick();
    check_eq("rst_valid",  {31'd0, bus_a.instr_valid}, 32'd0);
    check_eq("rst_halted", {31'd0, bus_a.halted},      32'd0);
    check_eq("rst_fault",  {31'd0, bus_a.fault},       32'd0);
    check_eq("rst_addr",   {24'd0, bus_a.rom_address}, 32'd0);
    check_eq("rst_instr",  {16'd0, bus_a.instr},       32'd0);
    rst_n = 1'b1;

    // Free-run until the halt opcode at address 6; dut_b tracks the same sequence.
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq($sformatf("seq_instr%0d", i), {16'd0, bus_a.instr}, {16'd0, exp_instr[i]});
      check_eq($sformatf("seq_pc%0d", i),    {24'd0, bus_a.instr_pc}, i);
      check_eq($sformatf("seq_valid%0d", i), {31'd0, bus_a.instr_valid}, 32'd1);
      check_eq($sformatf("b_pc%0d", i),      {24'd0, bus_b.instr_pc}, i);
    end
    check_eq("halted_after6", {31'd0, bus_a.halted}, 32'd1);
    check_eq("addr_after6",   {24'd0, bus_a.rom_address}, 32'd7);

    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq($sformatf("halt_valid%0d", i),  {31'd0, bus_a.instr_valid}, 32'd0);
      check_eq($sformatf("halt_addr%0d", i),   {24'd0, bus_a.rom_address}, 32'd7);
      check_eq($sformatf("b_wrap_pc%0d", i),   {24'd0, bus_b.instr_pc}, {24'd0, exp_b_pc[i]});
      check_eq($sformatf("b_wrap_ins%0d", i),  {16'd0, bus_b.instr},    {16'd0, exp_b[i]});
      check_eq($sformatf("b_halted%0d", i),    {31'd0, bus_b.halted},   32'd0);
    end

    // Redirect out of HALT to address 3.
    bus_a.redirect = 1'b1; bus_a.redirect_pc = 8'd3;
    tick();
    bus_a.redirect = 1'b0;
    check_eq("b_wrap_pc2",   {24'd0, bus_b.instr_pc}, {24'd0, exp_b_pc[2]});
    check_eq("redir_halted", {31'd0, bus_a.halted},      32'd0);
    check_eq("redir_valid",  {31'd0, bus_a.instr_valid}, 32'd0);
    check_eq("redir_addr",   {24'd0, bus_a.rom_address}, 32'd3);
    tick();
    check_eq("redir_instr", {16'd0, bus_a.instr},       32'h4001);
    check_eq("redir_pc",    {24'd0, bus_a.instr_pc},    32'd3);
    check_eq("redir_vld",   {31'd0, bus_a.instr_valid}, 32'd1);

    // Decoder stall for three cycles.
    bus_a.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("stall_instr%0d", i), {16'd0, bus_a.instr},       32'h4001);
      check_eq($sformatf("stall_pc%0d", i),    {24'd0, bus_a.instr_pc},    32'd3);
      check_eq($sformatf("stall_vld%0d", i),   {31'd0, bus_a.instr_valid}, 32'd1);
      check_eq($sformatf("stall_addr%0d", i),  {24'd0, bus_a.rom_address}, 32'd4);
    end
    bus_a.instr_ready = 1'b1;
    tick();
    check_eq("unstall_instr", {16'd0, bus_a.instr},    32'h5200);
    check_eq("unstall_pc",    {24'd0, bus_a.instr_pc}, 32'd4);

    // Redirect while a word is pending and not accepted: it is flushed.
    bus_a.instr_ready = 1'b0;
    bus_a.redirect = 1'b1; bus_a.redirect_pc = 8'd5;
    tick();
    bus_a.redirect = 1'b0; bus_a.instr_ready = 1'b1;
    check_eq("flush_valid", {31'd0, bus_a.instr_valid}, 32'd0);
    check_eq("flush_addr",  {24'd0, bus_a.rom_address}, 32'd5);
    tick();
    check_eq("flush_instr", {16'd0, bus_a.instr},       32'h1003);
    check_eq("flush_pc",    {24'd0, bus_a.instr_pc},    32'd5);
    check_eq("flush_vld",   {31'd0, bus_a.instr_valid}, 32'd1);

    // Out-of-range redirect target.
    bus_a.redirect = 1'b1; bus_a.redirect_pc = 8'd8;
    tick();
    bus_a.redirect = 1'b0;
    check_eq("fault_flag",   {31'd0, bus_a.fault},       32'd1);
    check_eq("fault_halted", {31'd0, bus_a.halted},      32'd1);
    check_eq("fault_valid",  {31'd0, bus_a.instr_valid}, 32'd0);
    check_eq("fault_addr",   {24'd0, bus_a.rom_address}, 32'd6);
    tick();
    bus_a.redirect = 1'b1; bus_a.redirect_pc = 8'd2;
    tick();
    bus_a.redirect = 1'b0;
    tick();
    check_eq("fault_sticky", {31'd0, bus_a.fault},       32'd1);
    check_eq("fault_novld",  {31'd0, bus_a.instr_valid}, 32'd0);
    check_eq("fault_pcheld", {24'd0, bus_a.rom_address}, 32'd6);

    // Asynchronous reset mid-cycle, release before the next edge.
    rst_n = 1'b0;
    #1;
    check_eq("areset_fault",  {31'd0, bus_a.fault},       32'd0);
    check_eq("areset_halted", {31'd0, bus_a.halted},      32'd0);
    check_eq("areset_addr",   {24'd0, bus_a.rom_address}, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check_eq("restart_instr", {16'd0, bus_a.instr},       32'h1003);
    check_eq("restart_pc",    {24'd0, bus_a.instr_pc},    32'd0);
    check_eq("restart_vld",   {31'd0, bus_a.instr_valid}, 32'd1);

    // Fetch enable low: pending word drains, PC frozen.
    bus_a.en = 1'b0;
    tick();
    check_eq("en0_valid", {31'd0, bus_a.instr_valid}, 32'd0);
    check_eq("en0_addr",  {24'd0, bus_a.rom_address}, 32'd1);
    tick();
    check_eq("en0_addr2", {24'd0, bus_a.rom_address}, 32'd1);
    bus_a.en = 1'b1;
    tick();
    check_eq("en1_instr", {16'd0, bus_a.instr},    32'hFFFF);
    check_eq("en1_pc",    {24'd0, bus_a.instr_pc}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
